// File: rtl/array_ops_pkg.sv
// Shared helpers for the array conversion blocks: beat count and the
// flat-index mapping used when turning a flat element stream into a grid.
package array_ops_pkg;

  // Number of beats needed to carry a full rows x cols grid.
  function automatic int beats_f(input int rows, input int cols, input int beat_elems);
    return (rows * cols) / beat_elems;
  endfunction

  // Flat stream position of grid element (i, j).
  // transpose=0: row index runs fastest (column-major stream).
  // transpose=1: column index runs fastest (row-major stream).
  function automatic int flat_index_f(input int i, input int j, input logic transpose,
                                      input int rows, input int cols);
    return transpose ? (i * cols + j) : (j * rows + i);
  endfunction

endpackage

// File: rtl/flat_to_grid_map.sv
// Combinational remap of a flat element buffer into a [ROWS][COLS] grid,
// with the fill order chosen by the transpose input.
module flat_to_grid_map
  import array_ops_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8
) (
  input  logic [ROWS*COLS*BIT_WIDTH-1:0] flat,
  input  logic                           transpose,
  output logic [BIT_WIDTH-1:0]           grid [ROWS][COLS]
);

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      localparam int K_COL = flat_index_f(i, j, 1'b0, ROWS, COLS);
      localparam int K_ROW = flat_index_f(i, j, 1'b1, ROWS, COLS);
      assign grid[i][j] = transpose ? flat[K_ROW*BIT_WIDTH +: BIT_WIDTH]
                                    : flat[K_COL*BIT_WIDTH +: BIT_WIDTH];
    end
  end

endmodule

// File: rtl/stream_1d_to_3d_array.sv
// Streaming beat-to-grid assembler. Beats fill a flat buffer; a completed
// frame is remapped into the grid-shaped output register, either on the
// completing edge (bypass) or later once the output register frees up.
module stream_1d_to_3d_array
  import array_ops_pkg::*;
#(
  parameter int BIT_WIDTH  = 4,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int BEAT_ELEMS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BEAT_ELEMS*BIT_WIDTH-1:0] in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_last,
  input  logic                            in_transpose,
  output logic [BIT_WIDTH-1:0]            out [ROWS][COLS],
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            err
);

  localparam int BEATS  = beats_f(ROWS, COLS, BEAT_ELEMS);
  localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FLAT_W = ROWS * COLS * BIT_WIDTH;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  if ((ROWS * COLS) % BEAT_ELEMS != 0) begin : g_bad_beat
    $error("BEAT_ELEMS must divide ROWS*COLS");
  end

  logic [CW-1:0]        bcnt;
  logic                 full;
  logic                 held;
  logic                 tr_q;
  logic [FLAT_W-1:0]    fill_q;
  logic [FLAT_W-1:0]    fill_next;
  logic [FLAT_W-1:0]    map_flat;
  logic                 map_tr;
  logic [BIT_WIDTH-1:0] grid [ROWS][COLS];
  logic                 accept;
  logic                 at_last;
  logic                 complete;
  logic                 transfer_full;
  logic                 bypass;
  logic                 load_out;

  // Stall only when a finished frame waits behind an unconsumed one.
  assign in_ready      = !rst && !(full && held && !out_ready);
  assign accept        = in_valid && in_ready;
  assign at_last       = (bcnt == LAST_CNT);
  assign complete      = accept && at_last;
  assign transfer_full = full && (!held || out_ready);
  assign bypass        = complete && !full && (!held || out_ready);
  assign load_out      = transfer_full || bypass;
  assign out_valid     = held;

  // Fill buffer with the current beat merged in, plus the remap source:
  // a waiting full frame takes priority, otherwise the in-flight frame
  // including this beat so completion can bypass straight to the output.
  always_comb begin
    fill_next = fill_q;
    if (accept) begin
      for (int e = 0; e < BEAT_ELEMS; e++) begin
        fill_next[(int'(bcnt) * BEAT_ELEMS + e) * BIT_WIDTH +: BIT_WIDTH] =
          in_data[e*BIT_WIDTH +: BIT_WIDTH];
      end
    end
    map_flat = full ? fill_q : fill_next;
    map_tr   = full ? tr_q : ((bcnt == '0) ? in_transpose : tr_q);
  end

  flat_to_grid_map #(
    .BIT_WIDTH (BIT_WIDTH),
    .ROWS      (ROWS),
    .COLS      (COLS)
  ) u_map (
    .flat      (map_flat),
    .transpose (map_tr),
    .grid      (grid)
  );

  // Fill buffer storage; every delivered frame rewrites all slots, so no reset.
  always_ff @(posedge clk) begin
    fill_q <= fill_next;
  end

  // Beat counter, transpose latch, full/held flags and framing error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt <= '0;
      tr_q <= 1'b0;
      full <= 1'b0;
      held <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (accept) begin
        if (bcnt == '0) tr_q <= in_transpose;
        if (at_last || in_last) bcnt <= '0;
        else                    bcnt <= bcnt + 1'b1;
      end
      full <= (full && !transfer_full) || (complete && !bypass);
      if (load_out)       held <= 1'b1;
      else if (out_ready) held <= 1'b0;
      err <= accept && (in_last != at_last);
    end
  end

  // Output grid register, loaded from the remap on every transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          out[i][j] <= '0;
    end else if (load_out) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          out[i][j] <= grid[i][j];
    end
  end

endmodule

// File: tb/tb_stream_1d_to_3d_array.sv
// Self-checking bench for stream_1d_to_3d_array: a frame-level reference
// model (queue of expected grids) checked against the DUT every cycle.
module tb_stream_1d_to_3d_array;

  localparam int BW    = 4;
  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int BE    = 4;
  localparam int BEATS = ROWS * COLS / BE;
  localparam int FW    = ROWS * COLS * BW;

  logic          clk = 1'b0;
  logic          rst;
  logic [BE*BW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic          in_transpose;
  logic [BW-1:0] out [ROWS][COLS];
  logic          out_valid;
  logic          out_ready;
  logic          err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [FW-1:0] exp_q[$];
  logic [BW-1:0] part [ROWS*COLS];
  int            mcnt = 0;
  bit            mtr = 1'b0;
  bit            err_exp = 1'b0;
  bit            m_rdy;
  bit            m_acc;
  bit            started = 1'b0;
  bit            rnd_done;

  stream_1d_to_3d_array #(
    .BIT_WIDTH  (BW),
    .ROWS       (ROWS),
    .COLS       (COLS),
    .BEAT_ELEMS (BE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_last      (in_last),
    .in_transpose (in_transpose),
    .out          (out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected grid, packed row-major, from the collected elements.
  function automatic logic [FW-1:0] map_frame(input bit tr);
    logic [FW-1:0] r;
    int k;
    r = '0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) begin
        k = tr ? (i * COLS + j) : (j * ROWS + i);
        r[(i*COLS+j)*BW +: BW] = part[k];
      end
    return r;
  endfunction

  function automatic logic [FW-1:0] pack_out();
    logic [FW-1:0] r;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        r[(i*COLS+j)*BW +: BW] = out[i][j];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [FW-1:0] act,
                             input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level model: a frame exists once its last beat is accepted and
  // leaves on an out handshake; at most two frames (held + full) coexist.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      mcnt    = 0;
      err_exp = 1'b0;
    end else begin
      m_rdy = !(exp_q.size() >= 2 && !out_ready);
      m_acc = in_valid && m_rdy;
      if (exp_q.size() >= 1 && out_ready) void'(exp_q.pop_front());
      err_exp = 1'b0;
      if (m_acc) begin
        if (mcnt == 0) mtr = in_transpose;
        for (int e = 0; e < BE; e++) part[mcnt*BE+e] = in_data[e*BW +: BW];
        if (mcnt == BEATS - 1) begin
          exp_q.push_back(map_frame(mtr));
          err_exp = !in_last;
          mcnt = 0;
        end else if (in_last) begin
          err_exp = 1'b1;
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("in_ready", FW'(in_ready),
                  FW'(rst ? 1'b0 : !(exp_q.size() >= 2 && !out_ready)));
      checkOutput("out_valid", FW'(out_valid), FW'(exp_q.size() >= 1));
      checkOutput("err", FW'(err), FW'(err_exp));
      if (exp_q.size() >= 1) checkOutput("out_grid", pack_out(), exp_q[0]);
    end
  end

  // Send nbeats beats; last_beat marks in_last (-1 for none); transpose
  // flips from toggle_beat on; data is k mod 16 or random.
  task automatic applyStimulus(input int nbeats, input int last_beat, input bit tr,
                               input int toggle_beat, input bit rnd);
    bit rdy;
    int budget;
    for (int b = 0; b < nbeats; b++) begin
      in_valid     = 1'b1;
      in_last      = (b == last_beat);
      in_transpose = (b >= toggle_beat) ? !tr : tr;
      for (int e = 0; e < BE; e++)
        in_data[e*BW +: BW] = rnd ? BW'($urandom) : BW'((b * BE + e) % 16);
      budget = 0;
      do begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        #1;
        budget++;
      end while (!rdy && budget < 2000);
      if (!rdy) begin
        checks++;
        errors++;
        $display("[TB] FAIL beat_timeout: in_ready stuck at 0 expected 1 (beat %0d)", b);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitValid(input string name);
    int budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!out_valid && budget < 200);
    if (!out_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: out_valid got 0 expected 1 within 200 cycles", name);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 200 && out_valid; n++) tick(1);
    checkOutput("drain_done", FW'(out_valid), FW'(0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_transpose = 1'b0;
    in_data = '0; out_ready = 1'b1; rnd_done = 1'b0;
    started = 1'b1;
    tick(3);
    checkOutput("rst_out_zero", pack_out(), FW'(0));
    checkOutput("rst_out_valid", FW'(out_valid), FW'(0));
    checkOutput("rst_in_ready", FW'(in_ready), FW'(0));
    checkOutput("rst_err", FW'(err), FW'(0));
    rst = 1'b0;
    tick(1);
    checkOutput("post_rst_in_ready", FW'(in_ready), FW'(1));

    // Column-major fill with k mod 16 data.
    applyStimulus(16, 15, 1'b0, 99, 1'b0);
    waitValid("t0_valid");
    checkOutput("t0_1_0", FW'(out[1][0]), FW'(1));
    checkOutput("t0_0_1", FW'(out[0][1]), FW'(8));
    checkOutput("t0_7_7", FW'(out[7][7]), FW'(15));
    checkOutput("t0_2_3", FW'(out[2][3]), FW'(10));
    tick(2);

    // Row-major fill; transpose toggle mid-frame must be ignored.
    applyStimulus(16, 15, 1'b1, 5, 1'b0);
    waitValid("t1_valid");
    checkOutput("t1_0_1", FW'(out[0][1]), FW'(1));
    checkOutput("t1_1_0", FW'(out[1][0]), FW'(8));
    checkOutput("t1_2_3", FW'(out[2][3]), FW'(3));
    tick(2);

    // Backpressure: three frames with out_ready low.
    out_ready = 1'b0;
    fork
      begin
        applyStimulus(16, 15, 1'b0, 99, 1'b1);
        applyStimulus(16, 15, 1'b1, 99, 1'b1);
        applyStimulus(16, 15, 1'b0, 99, 1'b1);
      end
      begin
        tick(40);
        checkOutput("bp_in_ready_low", FW'(in_ready), FW'(0));
        checkOutput("bp_held", FW'(out_valid), FW'(1));
        tick(5);
        out_ready = 1'b1;
      end
    join
    drain();

    // Early in_last on beat 9: discarded, then a good frame.
    applyStimulus(10, 9, 1'b0, 99, 1'b1);
    tick(3);
    checkOutput("discard_no_valid", FW'(out_valid), FW'(0));
    applyStimulus(16, 15, 1'b0, 99, 1'b0);
    waitValid("after_discard");
    checkOutput("after_discard_7_0", FW'(out[7][0]), FW'(7));
    tick(2);

    // Missing in_last: delivered with an error pulse.
    applyStimulus(16, -1, 1'b1, 99, 1'b1);
    tick(3);

    // Reset in the middle of a frame.
    applyStimulus(8, -1, 1'b0, 99, 1'b1);
    rst = 1'b1;
    tick(2);
    checkOutput("midrst_in_ready", FW'(in_ready), FW'(0));
    checkOutput("midrst_out_valid", FW'(out_valid), FW'(0));
    checkOutput("midrst_out_zero", pack_out(), FW'(0));
    rst = 1'b0;
    tick(1);
    applyStimulus(16, 15, 1'b1, 99, 1'b0);
    waitValid("after_rst");
    checkOutput("after_rst_0_1", FW'(out[0][1]), FW'(1));
    tick(2);

    // Randomized frames with random output backpressure.
    fork
      begin
        for (int f = 0; f < 8; f++) begin
          applyStimulus(16, 15, 1'($urandom), int'($urandom_range(0, 20)), 1'b1);
          tick(int'($urandom_range(0, 3)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          tick(1);
          out_ready = 1'($urandom);
        end
      end
    join
    drain();
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_1d_to_3d_array.md
# stream_1d_to_3d_array

Streaming successor to the team's combinational 1-D→3-D array converters. Accepts a flattened ROWS×COLS array of BIT_WIDTH-bit elements as a sequence of BEAT_ELEMS-wide beats over a valid/ready handshake. Assembles the beats into a full grid, selecting the fill order per frame. Presents the grid as an unpacked `[ROWS][COLS]` array with its own valid/ready. Sits between narrow memory/bus readers and array-consuming compute blocks. Double-buffered, so the next frame fills while the current one is held.

## Interface
- BIT_WIDTH, 4, bits per element
- ROWS, 8, grid rows
- COLS, 8, grid columns
- BEAT_ELEMS, 4, elements per input beat; must divide ROWS*COLS (elaboration error otherwise)
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_data  in  BEAT_ELEMS*BIT_WIDTH  beat payload; element e at `[e*BIT_WIDTH +: BIT_WIDTH]`
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_last  in  1  marks final beat of a frame
- in_transpose  in  1  fill order; sampled on the first beat of each frame only
- out  out  BIT_WIDTH × [ROWS][COLS]  assembled grid, unpacked
- out_valid  out  1  grid valid
- out_ready  in  1  grid consumed when out_valid && out_ready
- err  out  1  one-cycle pulse on a framing error

## Operation
- BEATS = ROWS*COLS/BEAT_ELEMS.
- Beat counter `bcnt` has width max(1, $clog2(BEATS)).
- Beat b, element e carries flat index k = b*BEAT_ELEMS + e.
- Mapping with transpose=0: k = j*ROWS + i, row index fastest; element goes to out[i][j].
- Mapping with transpose=1: k = i*COLS + j, column index fastest.
- Transpose latched at bcnt==0 acceptance; held for the rest of the frame.
- Storage:
  - fill buffer, flat ROWS*COLS*BIT_WIDTH;
  - output register, grid-shaped, driving `out`;
  - flag `held` (= out_valid).
- Accepted beat writes its BEAT_ELEMS slots in the fill buffer and increments bcnt.
- Frame complete on acceptance with bcnt==BEATS-1:
  - bcnt wraps to 0;
  - fill buffer marked `full`.
- Transfer when full && (!held || out_ready): fill buffer is mapped into the output register, held←1, full←0.
- Transfer happens on the same edge as the completing beat when possible, i.e. a full-bypass path.
- Consumption (held && out_ready, no transfer same cycle) clears held.
- in_ready = !rst && !(full && held && !out_ready).
- Framing rules:
  - in_last on a beat with bcnt<BEATS-1: frame discarded (bcnt←0, nothing transferred), err pulses.
  - Completing beat without in_last: frame still delivered, err pulses.
- Simultaneous consume and transfer: the output register takes the new frame, out_valid stays 1.
- Reset mid-frame: partial frame discarded, nothing emitted.

## Timing
- Reset values: out_valid=0, err=0, out=all zeros, bcnt=0, full=0, in_ready=0 while rst=1.
- in_ready=1 the cycle after rst deasserts.
- Latency: completing beat accepted at edge t; out_valid=1 and new grid on `out` after edge t (visible cycle t+1) if the output register was free or drained at t.
- Throughput: one beat per cycle sustained when out_ready=1; no bubble between frames.
- Backpressure: if held && !out_ready, the next frame still fills completely. in_ready drops only once that frame is full. The first beat of frame N+2 stalls.
- out and out_valid are stable while out_valid && !out_ready.
- err is registered: asserts the cycle after the offending beat, for exactly one cycle.

## Structure
- Shared package `array_ops_pkg`:
  - function `beats_f(ROWS, COLS, BEAT_ELEMS)`;
  - function `flat_index_f(i, j, transpose, ROWS, COLS)`.
- Sub-module `flat_to_grid_map`: combinational flat buffer + transpose → grid, built from generate loops over i/j.
  - Instantiated once on the transfer path.
  - Reusable by other blocks.
- Top level holds the counter, handshake, fill buffer, output register and err logic.

## Test plan
- Defaults, transpose=0, 16 beats carrying k=0..63 (element value = k mod 16), out_ready=1 → out[i][j]=(j*8+i) mod 16, out_valid one cycle after beat 15, err=0.
- Same stream with transpose=1 → out[i][j]=(i*8+j) mod 16; a transpose toggle at beat 5 is ignored.
- out_ready=0, three back-to-back frames → frame 1 held, frame 2 fills, in_ready=0 at the first beat of frame 3. Release out_ready → frames 1, 2, 3 emitted in order with no data corruption.
- in_last on beat 9 → err pulse, no out_valid. The following 16-beat frame is delivered correctly.
- 16 beats with no in_last → frame delivered and err pulses once.
- rst asserted after beat 7 → out_valid=0, in_ready=0 during reset. The next full frame is delivered with bcnt restarted at 0.
